// File: rtl/iceboard_status_rx.sv
// ============================================================================
// Module   : iceboard_status_rx
// Purpose  : 8N1 UART receiver and status-frame decoder for iCE motor boards.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iceboard_status_rx #(
    parameter int CLOCK_SPEED_HZ   = 50_000_000,
    parameter int BAUD_RATE        = 2_000_000,
    parameter int NUMBER_OF_MOTORS = 6,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    output logic        status_valid,
    output logic [7:0]  status_motor,
    output logic [31:0] status_position,
    output logic [31:0] status_velocity,
    output logic [31:0] status_displacement,
    output logic [15:0] status_current,
    output logic        frame_error,
    output logic        checksum_error,
    output logic [15:0] error_count
);

    localparam int c_BIT_TICKS    = CLOCK_SPEED_HZ / BAUD_RATE;
    localparam int c_HALF_TICKS   = c_BIT_TICKS / 2;
    localparam int c_TICK_W       = $clog2(c_BIT_TICKS) + 1;
    localparam int c_TIMEOUT_CLKS = TIMEOUT_BITS * c_BIT_TICKS;
    localparam int c_GAP_W        = $clog2(c_TIMEOUT_CLKS + 1) + 1;

    typedef enum logic [2:0] {
        BIT_IDLE, BIT_START, BIT_DATA, BIT_STOP, BIT_WAIT_HIGH
    } bit_state_t;

    typedef enum logic [2:0] {
        FR_HUNT_SYNC0, FR_HUNT_SYNC1, FR_ID, FR_PAYLOAD, FR_CHECK
    } frame_state_t;

    bit_state_t          r_bstate;
    logic                r_rx_meta;
    logic                r_rx_sync;
    logic                r_rx_prev;
    logic [c_TICK_W-1:0] r_tick;
    logic [2:0]          r_bit_cnt;
    logic [7:0]          r_shift;
    logic [7:0]          r_byte;
    logic                r_byte_valid;
    logic                r_frame_error;

    frame_state_t        r_fstate;
    logic [7:0]          r_id;
    logic [7:0]          r_sum;
    logic [3:0]          r_byte_cnt;
    logic [111:0]        r_shadow;
    logic [c_GAP_W-1:0]  r_gap;
    logic                r_status_valid;
    logic                r_checksum_error;
    logic [7:0]          r_motor;
    logic [31:0]         r_position;
    logic [31:0]         r_velocity;
    logic [31:0]         r_displacement;
    logic [15:0]         r_current;
    logic [15:0]         r_error_count;

    logic w_in_frame;
    logic w_timeout;
    logic w_err_event;
    logic w_id_ok;

    // Bit-level receiver, including the rx synchroniser
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_bstate      <= BIT_IDLE;
            r_rx_meta     <= 1'b1;
            r_rx_sync     <= 1'b1;
            r_rx_prev     <= 1'b1;
            r_tick        <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_byte        <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_rx_meta     <= rx;
            r_rx_sync     <= r_rx_meta;
            r_rx_prev     <= r_rx_sync;
            r_byte_valid  <= 1'b0;
            r_frame_error <= 1'b0;
            case (r_bstate)
                BIT_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_bstate <= BIT_START;
                        r_tick   <= '0;
                    end
                end
                BIT_START: begin
                    if (r_tick == c_TICK_W'(c_HALF_TICKS)) begin
                        r_tick    <= '0;
                        r_bit_cnt <= '0;
                        r_bstate  <= r_rx_sync ? BIT_IDLE : BIT_DATA;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                BIT_DATA: begin
                    if (r_tick == c_TICK_W'(c_BIT_TICKS - 1)) begin
                        r_tick    <= '0;
                        r_shift   <= {r_rx_sync, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == 3'd7) begin
                            r_bstate <= BIT_STOP;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                BIT_STOP: begin
                    if (r_tick == c_TICK_W'(c_BIT_TICKS - 1)) begin
                        r_tick <= '0;
                        if (r_rx_sync) begin
                            r_byte       <= r_shift;
                            r_byte_valid <= 1'b1;
                            r_bstate     <= BIT_IDLE;
                        end else begin
                            r_frame_error <= 1'b1;
                            r_bstate      <= BIT_WAIT_HIGH;
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                BIT_WAIT_HIGH: begin
                    if (r_rx_sync) begin
                        r_bstate <= BIT_IDLE;
                    end
                end
                default: r_bstate <= BIT_IDLE;
            endcase
        end
    end

    assign w_in_frame  = (r_fstate == FR_ID) || (r_fstate == FR_PAYLOAD) || (r_fstate == FR_CHECK);
    assign w_timeout   = w_in_frame && !r_byte_valid && (r_gap >= c_GAP_W'(c_TIMEOUT_CLKS));
    assign w_err_event = r_frame_error || r_checksum_error || w_timeout;
    assign w_id_ok     = ({24'd0, r_id} < 32'(NUMBER_OF_MOTORS));

    // Frame-level decoder; a stop-bit error or an idle gap aborts the frame
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_fstate         <= FR_HUNT_SYNC0;
            r_id             <= '0;
            r_sum            <= '0;
            r_byte_cnt       <= '0;
            r_shadow         <= '0;
            r_gap            <= '0;
            r_status_valid   <= 1'b0;
            r_checksum_error <= 1'b0;
            r_motor          <= '0;
            r_position       <= '0;
            r_velocity       <= '0;
            r_displacement   <= '0;
            r_current        <= '0;
            r_error_count    <= '0;
        end else begin
            r_status_valid   <= 1'b0;
            r_checksum_error <= 1'b0;

            if (w_err_event && (r_error_count != 16'hFFFF)) begin
                r_error_count <= r_error_count + 1'b1;
            end

            if (!w_in_frame || r_byte_valid) begin
                r_gap <= '0;
            end else if (!w_timeout) begin
                r_gap <= r_gap + 1'b1;
            end

            if (r_frame_error || w_timeout) begin
                r_fstate <= FR_HUNT_SYNC0;
            end else if (r_byte_valid) begin
                case (r_fstate)
                    FR_HUNT_SYNC0: begin
                        if (r_byte == 8'hAA) r_fstate <= FR_HUNT_SYNC1;
                    end
                    FR_HUNT_SYNC1: begin
                        if (r_byte == 8'h55)      r_fstate <= FR_ID;
                        else if (r_byte != 8'hAA) r_fstate <= FR_HUNT_SYNC0;
                    end
                    FR_ID: begin
                        r_id       <= r_byte;
                        r_sum      <= r_byte;
                        r_byte_cnt <= '0;
                        r_fstate   <= FR_PAYLOAD;
                    end
                    FR_PAYLOAD: begin
                        r_shadow   <= {r_shadow[103:0], r_byte};
                        r_sum      <= r_sum + r_byte;
                        r_byte_cnt <= r_byte_cnt + 1'b1;
                        if (r_byte_cnt == 4'd13) r_fstate <= FR_CHECK;
                    end
                    FR_CHECK: begin
                        if ((r_byte == r_sum) && w_id_ok) begin
                            r_status_valid <= 1'b1;
                            r_motor        <= r_id;
                            r_position     <= r_shadow[111:80];
                            r_velocity     <= r_shadow[79:48];
                            r_displacement <= r_shadow[47:16];
                            r_current      <= r_shadow[15:0];
                        end else begin
                            r_checksum_error <= 1'b1;
                        end
                        r_fstate <= FR_HUNT_SYNC0;
                    end
                    default: r_fstate <= FR_HUNT_SYNC0;
                endcase
            end
        end
    end

    assign status_valid        = r_status_valid;
    assign status_motor        = r_motor;
    assign status_position     = r_position;
    assign status_velocity     = r_velocity;
    assign status_displacement = r_displacement;
    assign status_current      = r_current;
    assign frame_error         = r_frame_error;
    assign checksum_error      = r_checksum_error;
    assign error_count         = r_error_count;

endmodule

`default_nettype wire

// File: tb/tb_iceboard_status_rx.sv
// ============================================================================
// Module   : tb_iceboard_status_rx
// Purpose  : Directed bench with a frame-level reference model for iceboard_status_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iceboard_status_rx;

    localparam int BIT = 25;
    localparam int NM  = 6;

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [7:0]  motor;
        logic [31:0] pos;
        logic [31:0] vel;
        logic [31:0] disp;
        logic [15:0] cur;
    } stat_t;

    logic        clock;
    logic        reset_n;
    logic        rx;
    logic        status_valid;
    logic [7:0]  status_motor;
    logic [31:0] status_position;
    logic [31:0] status_velocity;
    logic [31:0] status_displacement;
    logic [15:0] status_current;
    logic        frame_error;
    logic        checksum_error;
    logic [15:0] error_count;

    iceboard_status_rx dut (
        .clock               (clock),
        .reset_n             (reset_n),
        .rx                  (rx),
        .status_valid        (status_valid),
        .status_motor        (status_motor),
        .status_position     (status_position),
        .status_velocity     (status_velocity),
        .status_displacement (status_displacement),
        .status_current      (status_current),
        .frame_error         (frame_error),
        .checksum_error      (checksum_error),
        .error_count         (error_count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    int    checks = 0;
    int    errors = 0;
    stat_t exp_q[$];
    stat_t held = '0;
    stat_t prev_out = '0;
    int    exp_sv = 0, exp_ce = 0, exp_fe = 0, exp_err = 0;
    int    n_sv = 0, n_ce = 0, n_fe = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: locate AA 55 headers, validate id and sum, queue results
    task automatic predict(input bq_t s);
        int         i;
        logic [7:0] sum;
        stat_t      e;
        i = 0;
        while (i + 17 < s.size()) begin
            if (s[i] == 8'hAA && s[i+1] == 8'h55) begin
                sum = 8'h00;
                for (int k = 2; k <= 16; k++) sum = sum + s[i+k];
                if (sum == s[i+17] && int'(s[i+2]) < NM) begin
                    e.motor = s[i+2];
                    e.pos   = {s[i+3],  s[i+4],  s[i+5],  s[i+6]};
                    e.vel   = {s[i+7],  s[i+8],  s[i+9],  s[i+10]};
                    e.disp  = {s[i+11], s[i+12], s[i+13], s[i+14]};
                    e.cur   = {s[i+15], s[i+16]};
                    exp_q.push_back(e);
                    exp_sv++;
                end else begin
                    exp_ce++;
                    exp_err++;
                end
                i += 18;
            end else begin
                i++;
            end
        end
    endtask

    function automatic bq_t make_frame(input logic [7:0] id, input logic [31:0] pos,
                                       input logic [31:0] vel, input logic [31:0] disp,
                                       input logic [15:0] cur, input logic [7:0] chk_adj);
        bq_t        q;
        logic [7:0] sum;
        q = '{8'hAA, 8'h55, id, pos[31:24], pos[23:16], pos[15:8], pos[7:0],
              vel[31:24], vel[23:16], vel[15:8], vel[7:0],
              disp[31:24], disp[23:16], disp[15:8], disp[7:0], cur[15:8], cur[7:0]};
        sum = 8'h00;
        for (int k = 2; k < 17; k++) sum = sum + q[k];
        q.push_back(sum + chk_adj);
        return q;
    endfunction

    always @(negedge clock) begin
        stat_t cur_out;
        cur_out = {status_motor, status_position, status_velocity, status_displacement, status_current};
        if (status_valid) begin
            n_sv++;
            if (exp_q.size() == 0) begin
                check("unexpected_status_valid", 1, 0);
            end else begin
                held = exp_q.pop_front();
            end
        end
        if (checksum_error) n_ce++;
        if (frame_error)    n_fe++;
        if (status_valid || cur_out != prev_out || !reset_n) begin
            check("status_outputs", cur_out, held);
        end
        prev_out = cur_out;
    end

    task automatic send_bit(input logic v);
        rx = v;
        repeat (BIT) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        if (bad_stop) send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic send_stream(input bq_t s, input int first, input int last);
        for (int i = first; i <= last; i++) send_byte(s[i], 1'b0);
    endtask

    task automatic end_case(input string name);
        repeat (2 * BIT) @(negedge clock);
        check({name, "_pending"},  exp_q.size(), 0);
        check({name, "_valids"},   n_sv, exp_sv);
        check({name, "_chk_errs"}, n_ce, exp_ce);
        check({name, "_frm_errs"}, n_fe, exp_fe);
        check({name, "_err_cnt"},  error_count, exp_err);
    endtask

    task automatic assert_reset(input string name);
        @(negedge clock);
        #2;
        reset_n = 1'b0;
        held    = '0;
        exp_q.delete();
        exp_err = 0;
        @(negedge clock);
        check({name, "_rst_outs"}, {status_motor, status_position, status_velocity,
                                    status_displacement, status_current}, 0);
        check({name, "_rst_pulses"}, {status_valid, frame_error, checksum_error}, 0);
        check({name, "_rst_errcnt"}, error_count, 0);
    endtask

    initial begin
        bq_t f1, f1_bad, f_id6, f_b, s5, lit;
        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (5) @(negedge clock);
        check("reset_outs", {status_motor, status_position, status_velocity,
                             status_displacement, status_current}, 0);
        check("reset_errcnt", error_count, 0);
        reset_n = 1'b1;
        repeat (4 * BIT) @(negedge clock);

        lit = '{8'hAA, 8'h55, 8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF, 8'hFF,
                8'hF6, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h50, 8'h66};
        f1 = make_frame(8'h02, 32'd256, 32'hFFFF_FFF6, 32'd32, 16'h0050, 8'h00);
        check("model_chk_byte", f1[17], 8'h66);
        check("model_frame_len", f1.size(), lit.size());

        // 1: valid frame from the literal vector
        predict(lit);
        send_stream(lit, 0, 17);
        end_case("c1");
        check("c1_motor", status_motor, 8'd2);
        check("c1_position", status_position, 32'd256);
        check("c1_velocity", status_velocity, 32'hFFFF_FFF6);
        check("c1_displacement", status_displacement, 32'd32);
        check("c1_current", status_current, 16'h0050);

        // 2: checksum off by one
        f1_bad = make_frame(8'h02, 32'd256, 32'hFFFF_FFF6, 32'd32, 16'h0050, 8'h01);
        check("model_bad_chk", f1_bad[17], 8'h67);
        predict(f1_bad);
        send_stream(f1_bad, 0, 17);
        end_case("c2");
        check("c2_hold_position", status_position, 32'd256);

        // 3: out-of-range id with a matching checksum
        f_id6 = make_frame(8'h06, 32'd256, 32'hFFFF_FFF6, 32'd32, 16'h0050, 8'h00);
        check("model_id6_chk", f_id6[17], 8'h6A);
        predict(f_id6);
        send_stream(f_id6, 0, 17);
        end_case("c3");
        check("c3_errcnt_literal", error_count, 16'd2);

        // 4: bad stop bit on the 5th payload byte, then a good frame
        assert_reset("c4");
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        send_stream(f1, 0, 6);
        send_byte(8'hFF, 1'b1);
        exp_fe++;
        exp_err++;
        predict(f1);
        send_stream(f1, 0, 17);
        end_case("c4");

        // extra pattern: negative values and top id
        f_b = make_frame(8'h05, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 16'h8001, 8'h00);
        predict(f_b);
        send_stream(f_b, 0, 17);
        end_case("cb");
        check("cb_current", status_current, 16'h8001);

        // 5: garbage then resync
        s5 = '{8'h12, 8'hAA};
        for (int i = 0; i < 18; i++) s5.push_back(f1[i]);
        predict(s5);
        send_stream(s5, 0, 19);
        end_case("c5");
        check("c5_motor", status_motor, 8'd2);

        // 6a: idle gap after byte 8 of a frame
        send_stream(f1, 0, 7);
        repeat (25 * BIT) @(negedge clock);
        exp_err++;
        send_stream(f1, 8, 17);
        end_case("c6a");

        // 6b: short low glitch on an idle line
        rx = 1'b0;
        repeat (8) @(negedge clock);
        rx = 1'b1;
        end_case("c6b");

        // 6c: reset mid-byte inside a frame, then a full frame
        send_stream(f1, 0, 4);
        rx = 1'b0;
        repeat (10) @(negedge clock);
        assert_reset("c6c");
        rx = 1'b1;
        repeat (BIT) @(negedge clock);
        reset_n = 1'b1;
        repeat (2 * BIT) @(negedge clock);
        predict(f1);
        send_stream(f1, 0, 17);
        end_case("c6c");
        check("c6c_velocity", status_velocity, 32'hFFFF_FFF6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
